// File: rtl/serial_shr_pkg.sv
// Shared definitions for the serial shifter family (right shifter now, left shifter later).
package serial_shr_pkg;

  localparam int DEF_DATAWIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shr_state_e;

endpackage

// File: rtl/serial_shr.sv
// Multi-cycle right shifter: one bit per cycle, logical or arithmetic fill.
// Latency k+2 edges from acceptance (k = min(sh_amt, DATAWIDTH)); start ignored while busy.
module serial_shr
  import serial_shr_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  input  logic                 arith,
  output logic [DATAWIDTH-1:0] d,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [DATAWIDTH:0] AMT_MAX = (DATAWIDTH + 1)'(DATAWIDTH);
  localparam logic [CW-1:0]      K_MAX   = CW'(DATAWIDTH);

  shr_state_e           state_q, state_d;
  logic [DATAWIDTH-1:0] work_q, work_d;
  logic [DATAWIDTH-1:0] d_q, d_d;
  logic [CW-1:0]        k_q, k_d, k_load;
  logic                 arith_q, arith_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Amounts of DATAWIDTH or more all produce the fully-filled result, so clamp.
  assign k_load = ({1'b0, sh_amt} >= AMT_MAX) ? K_MAX : CW'(sh_amt);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    d_d     = d_q;
    k_d     = k_q;
    arith_d = arith_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          work_d  = a;
          arith_d = arith;
          k_d     = k_load;
          busy_d  = 1'b1;
          state_d = (k_load != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        // Sign fill keeps the MSB stable, so work_q's MSB is the captured operand MSB.
        work_d = {arith_q & work_q[DATAWIDTH-1], work_q[DATAWIDTH-1:1]};
        k_d    = k_q - CW'(1);
        if (k_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        d_d     = work_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      d_q     <= '0;
      k_q     <= '0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      d_q     <= d_d;
      k_q     <= k_d;
      arith_q <= arith_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d    = d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_shr.sv
// Self-checking bench for serial_shr: vector table, corner sequences, random back-to-back ops.
module tb_serial_shr;

  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] amt;
    logic       ar;
    logic [7:0] exp_d;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] sh_amt;
  logic       arith;
  logic [7:0] d;
  logic       busy;
  logic       done;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         start_cnt = 0;
  int         done_cnt  = 0;
  logic [7:0] exp_q[$];

  serial_shr #(.DATAWIDTH(W)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (start),
    .a      (a),
    .sh_amt (sh_amt),
    .arith  (arith),
    .d      (d),
    .busy   (busy),
    .done   (done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_shr(input logic [7:0] v, input logic [7:0] amt, input logic ar);
    if (amt >= 8'd8) return (ar && v[7]) ? 8'hFF : 8'h00;
    if (ar) return 8'($signed(v) >>> amt);
    return v >> amt;
  endfunction

  // Called at a negedge; drives start immediately so back-to-back calls hit the IDLE cycle.
  task automatic do_op(input logic [7:0] av, input logic [7:0] amt, input logic ar,
                       input logic [7:0] exp_d, input bit glitch);
    int         k;
    int         cyc;
    int         busy_cyc;
    bit         seen;
    logic [7:0] exp_v;
    k = (amt > 8'd8) ? 8 : int'(amt);
    a = av; sh_amt = amt; arith = ar; start = 1'b1;
    exp_q.push_back(exp_d);
    start_cnt++;
    @(negedge Clk);
    start = 1'b0; a = ~av; sh_amt = 8'(amt + 8'd3); arith = ~ar;
    check("done_low_after_accept", {31'd0, done}, 32'd0);
    cyc = 1; busy_cyc = 0; seen = 1'b0;
    while (cyc < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      if (glitch && cyc == 2) begin
        start = 1'b1; a = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      done_cnt++;
      check("latency", cyc, k + 2);
      check("busy_cycles", busy_cyc, k + 1);
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("d_result", {24'd0, d}, {24'd0, exp_v});
      end else begin
        check("scoreboard_nonempty", 32'd0, 32'd1);
      end
    end
  endtask

  initial begin
    vec_t       vecs[10];
    int         extra;
    logic [7:0] ra, ramt;
    logic       rar;

    vecs[0] = '{8'hB4, 8'd3,   1'b0, 8'h16};
    vecs[1] = '{8'hB4, 8'd3,   1'b1, 8'hF6};
    vecs[2] = '{8'h5A, 8'd0,   1'b0, 8'h5A};
    vecs[3] = '{8'h80, 8'd200, 1'b1, 8'hFF};
    vecs[4] = '{8'h80, 8'd200, 1'b0, 8'h00};
    vecs[5] = '{8'h80, 8'd8,   1'b1, 8'hFF};
    vecs[6] = '{8'h7F, 8'd7,   1'b0, 8'h00};
    vecs[7] = '{8'h81, 8'd1,   1'b1, 8'hC0};
    vecs[8] = '{8'h81, 8'd7,   1'b1, 8'hFF};
    vecs[9] = '{8'hC3, 8'd9,   1'b0, 8'h00};

    // Reset with start held high: reset must win.
    Rst = 1'b0; start = 1'b1; a = 8'hAA; sh_amt = 8'd2; arith = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_d", {24'd0, d}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    Rst = 1'b1;

    // First op issued with the release: accepted on the first edge with Rst high.
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].a, vecs[i].amt, vecs[i].ar, vecs[i].exp_d, 1'b0);

    // Start pulse during SHIFT must be ignored.
    do_op(8'hF0, 8'd4, 1'b0, 8'h0F, 1'b1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (done) extra++;
    end
    check("no_extra_done", extra, 0);

    // Reset during the third SHIFT cycle aborts the op.
    a = 8'hFF; sh_amt = 8'd7; arith = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("abort_d", {24'd0, d}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    Rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (done) extra++;
    end
    check("no_done_after_abort", extra, 0);
    do_op(8'h80, 8'd1, 1'b0, 8'h40, 1'b0);

    // Random back-to-back operations against the reference shift.
    for (int i = 0; i < 1000; i++) begin
      ra   = 8'($urandom);
      ramt = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      rar  = 1'($urandom);
      do_op(ra, ramt, rar, ref_shr(ra, ramt, rar), 1'b0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    check("done_count", done_cnt, start_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
